// File: rtl/sample_feeder.sv
// Training-sample buffer feeding a single neuron: loads up to DEPTH samples
// (N features + label, Q8.8) as a word stream, then replays them on `next`.
module sample_feeder #(
  parameter int N     = 6,
  parameter int BITS  = 16,
  parameter int DEPTH = 8,
  parameter int EW    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reload,
  input  logic                          ld_valid,
  input  logic [BITS-1:0]               ld_data,
  input  logic                          ld_last,
  output logic                          ld_ready,
  input  logic                          next,
  output logic [N-1:0][BITS-1:0]        x,
  output logic [BITS-1:0]               y_true,
  output logic                          x_valid,
  output logic [$clog2(DEPTH)-1:0]      idx,
  output logic                          epoch_done,
  output logic [EW-1:0]                 epochs
);

  localparam int IW = $clog2(DEPTH);
  localparam int WW = $clog2(N + 1);
  localparam logic [WW-1:0] LABEL_W = WW'(N);
  localparam logic [IW-1:0] LAST_S  = IW'(DEPTH - 1);

  typedef enum logic {LOAD, RUN} state_t;

  state_t                  state_q, state_d;
  logic [WW-1:0]           w_q, w_d;
  logic [IW-1:0]           s_q, s_d;
  logic [IW-1:0]           last_q, last_d;   // index of the final stored sample
  logic [IW-1:0]           idx_q, idx_d;
  logic [EW-1:0]           epochs_q, epochs_d;
  logic                    done_q, done_d;
  logic [N-1:0][BITS-1:0]  x_q, x_d;
  logic [BITS-1:0]         y_q, y_d;
  logic                    wr_en;

  logic [BITS-1:0]         mem [DEPTH][N+1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    s_d      = s_q;
    last_d   = last_q;
    idx_d    = idx_q;
    epochs_d = epochs_q;
    done_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    wr_en    = 1'b0;

    if (reload) begin
      state_d  = LOAD;
      w_d      = '0;
      s_d      = '0;
      last_d   = '0;
      idx_d    = '0;
      epochs_d = '0;
      x_d      = '0;
      y_d      = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (ld_valid) begin
            wr_en = 1'b1;
            if (w_q == LABEL_W) begin
              w_d = '0;
              s_d = s_q + 1'b1;
              if (ld_last || s_q == LAST_S) begin
                state_d = RUN;
                last_d  = s_q;
                idx_d   = '0;
                for (int k = 0; k < N; k++) x_d[k] = mem[0][k];
                // A one-sample set has its label arriving right now.
                y_d = (s_q == '0) ? ld_data : mem[0][N];
              end
            end else begin
              w_d = w_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (next) begin
            if (idx_q == last_q) begin
              idx_d  = '0;
              done_d = 1'b1;
              if (epochs_q != '1) epochs_d = epochs_q + 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
            for (int k = 0; k < N; k++) x_d[k] = mem[idx_d][k];
            y_d = mem[idx_d][N];
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      w_q      <= '0;
      s_q      <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      epochs_q <= '0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      s_q      <= s_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      epochs_q <= epochs_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  // NOTE: the sample store has no reset; its contents are only read after a load.
  always_ff @(posedge clk) begin
    if (wr_en) mem[s_q][w_q] <= ld_data;
  end

  assign ld_ready   = (state_q == LOAD);
  assign x_valid    = (state_q == RUN);
  assign x          = x_q;
  assign y_true     = y_q;
  assign idx        = idx_q;
  assign epoch_done = done_q;
  assign epochs     = epochs_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: a queue-based dataset model checked every cycle,
// plus directed literal checks of load, replay, wrap, saturation and resets.
module tb_sample_feeder;

  localparam int N     = 6;
  localparam int BITS  = 16;
  localparam int DEPTH = 8;
  localparam int EW    = 2;
  localparam int SW    = N + 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       reload = 1'b0;
  logic                       ld_valid = 1'b0;
  logic [BITS-1:0]            ld_data = '0;
  logic                       ld_last = 1'b0;
  logic                       ld_ready;
  logic                       next = 1'b0;
  logic [N-1:0][BITS-1:0]     x;
  logic [BITS-1:0]            y_true;
  logic                       x_valid;
  logic [$clog2(DEPTH)-1:0]   idx;
  logic                       epoch_done;
  logic [EW-1:0]              epochs;

  sample_feeder #(.N(N), .BITS(BITS), .DEPTH(DEPTH), .EW(EW)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .next(next), .x(x), .y_true(y_true), .x_valid(x_valid), .idx(idx),
    .epoch_done(epoch_done), .epochs(epochs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the dataset is a flat list of accepted words.
  logic [BITS-1:0] m_words[$];
  bit  m_init = 0;
  bit  m_run;
  int  m_n, m_idx, m_epochs;
  bit  m_done;

  task automatic m_reset();
    m_run = 0; m_words.delete(); m_n = 0; m_idx = 0; m_epochs = 0; m_done = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1;
      m_reset();
    end else if (m_init) begin
      if (reload) m_reset();
      else if (!m_run) begin
        m_done = 0;
        if (ld_valid) begin
          m_words.push_back(ld_data);
          if (m_words.size() % SW == 0) begin
            int s;
            s = m_words.size() / SW;
            if (ld_last || s == DEPTH) begin
              m_run = 1; m_n = s; m_idx = 0;
            end
          end
        end
      end else begin
        m_done = 0;
        if (next) begin
          if (m_idx == m_n - 1) begin
            m_idx = 0; m_done = 1;
            if (m_epochs < (1 << EW) - 1) m_epochs++;
          end else m_idx++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [N-1:0][BITS-1:0] ex;
      logic [BITS-1:0] ey;
      ex = '0; ey = '0;
      if (m_run) begin
        for (int k = 0; k < N; k++) ex[k] = m_words[m_idx*SW + k];
        ey = m_words[m_idx*SW + N];
      end
      check("m_ld_ready", ld_ready, !m_run);
      check("m_x_valid", x_valid, m_run);
      check("m_idx", idx, m_idx);
      check("m_epochs", epochs, m_epochs);
      check("m_epoch_done", epoch_done, m_done);
      check("m_x", x, ex);
      check("m_y_true", y_true, ey);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [BITS-1:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1; tick(); next = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1; tick(); reload = 1'b0;
  endtask

  logic [BITS-1:0] plan [14] = '{16'hFEEF, 16'h0201, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000,
                                 16'h0400, 16'hFD00, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};

  initial begin
    logic [N-1:0][BITS-1:0] px;
    logic [BITS-1:0] w [SW];
    int exp_ep [5] = '{1, 2, 3, 3, 3};

    tick(); tick();
    rst = 1'b0;
    check("rst_ld_ready", ld_ready, 1'b1);
    check("rst_x_valid", x_valid, 1'b0);
    check("rst_idx", idx, 0);
    check("rst_epochs", epochs, 0);
    check("rst_x", x, '0);

    // Two-sample load from the plan vectors.
    for (int i = 0; i < 14; i++) begin
      load_word(plan[i], i == 13);
      if (i == 12) check("x_valid_before_last", x_valid, 1'b0);
    end
    check("load_x_valid", x_valid, 1'b1);
    check("load_ld_ready", ld_ready, 1'b0);
    check("load_x0", x[0], 16'hFEEF);
    check("load_y", y_true, 16'h0000);
    check("load_idx", idx, 0);

    pulse_next();
    check("n1_x0", x[0], 16'h0400);
    check("n1_y", y_true, 16'h0100);
    check("n1_idx", idx, 1);
    check("n1_done", epoch_done, 1'b0);
    pulse_next();
    check("n2_idx", idx, 0);
    check("n2_x0", x[0], 16'hFEEF);
    check("n2_done", epoch_done, 1'b1);
    check("n2_epochs", epochs, 1);
    tick();
    check("n2_done_clear", epoch_done, 1'b0);

    // reload colliding with next at idx=1
    pulse_next();
    reload = 1'b1; next = 1'b1; tick(); reload = 1'b0; next = 1'b0;
    check("rl_x_valid", x_valid, 1'b0);
    check("rl_ld_ready", ld_ready, 1'b1);
    check("rl_idx", idx, 0);
    check("rl_epochs", epochs, 0);
    check("rl_done", epoch_done, 1'b0);

    // Fill to DEPTH; ld_last only ever on feature words, where it is ignored.
    for (int s = 0; s < DEPTH; s++)
      for (int k = 0; k < SW; k++) begin
        while ($urandom_range(3) == 0) tick();
        load_word(BITS'($urandom), (k < N) ? 1'($urandom_range(1)) : 1'b0);
      end
    check("full_ld_ready", ld_ready, 1'b0);
    check("full_x_valid", x_valid, 1'b1);
    load_word(16'hBEEF, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(1)) tick();
      pulse_next();
    end
    check("full_epochs", epochs, 1);
    check("full_idx", idx, 0);
    next = 1'b1; repeat (3) tick(); next = 1'b0;
    check("held_idx", idx, 3);

    // Saturation with a single sample and next held high.
    pulse_reload();
    for (int k = 0; k < SW; k++) load_word(16'h1000 + 16'(k), k == N);
    next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_epochs", epochs, exp_ep[i]);
      check("sat_done", epoch_done, 1'b1);
    end
    next = 1'b0;
    tick();
    check("sat_done_clear", epoch_done, 1'b0);

    // rst mid-load, then a fresh single-sample load.
    pulse_reload();
    for (int k = 0; k < 3; k++) load_word(16'hAAAA, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_ld_ready", ld_ready, 1'b1);
    check("mid_rst_x_valid", x_valid, 1'b0);
    for (int k = 0; k < SW; k++) begin
      w[k] = BITS'($urandom);
      load_word(w[k], k == N);
    end
    for (int k = 0; k < N; k++) px[k] = w[k];
    check("fresh_x", x, px);
    check("fresh_y", y_true, w[N]);
    check("fresh_idx", idx, 0);
    pulse_next();
    check("fresh_wrap_done", epoch_done, 1'b1);

    // Random rounds, checked by the per-cycle model.
    for (int r = 0; r < 25; r++) begin
      int ns;
      bit aborted;
      if ($urandom_range(3) == 0) begin rst = 1'b1; tick(); rst = 1'b0; end
      else pulse_reload();
      ns = $urandom_range(DEPTH, 1);
      aborted = 0;
      for (int s = 0; s < ns && !aborted; s++)
        for (int k = 0; k < SW && !aborted; k++) begin
          while ($urandom_range(3) == 0) tick();
          if ($urandom_range(60) == 0) begin
            reload = 1'b1; ld_valid = 1'b1; ld_data = BITS'($urandom);
            tick();
            reload = 1'b0; ld_valid = 1'b0;
            aborted = 1;
          end else
            load_word(BITS'($urandom), (k == N) ? (s == ns - 1) : 1'($urandom_range(1)));
        end
      repeat (30) begin
        next = 1'($urandom_range(1));
        ld_valid = 1'($urandom_range(1));
        ld_data = BITS'($urandom);
        if ($urandom_range(50) == 0) reload = 1'b1;
        tick();
        next = 1'b0; ld_valid = 1'b0; reload = 1'b0;
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
